accumulator_window_ctrl: RTL and testbench

- Downstream companion of `accumulator`: consumes its `sum`, drives its clear input, and turns the running total into a stream of per-window results.
- Every `WINDOW` cycles while enabled, it captures `sum` into a `DEPTH`-entry FIFO and pulses the clear in the same cycle. The next window therefore starts from zero.
- Results leave on a valid/ready port. If the FIFO is full when a result arrives, the result is dropped and a sticky overflow flag is set.

---
 rtl/accumulator_pkg.sv | 10 +
 rtl/accumulator_window_ctrl_if.sv | 15 +
 rtl/sum_fifo.sv | 52 +++++
 rtl/accumulator_window_ctrl.sv | 69 ++++++
 tb/tb_accumulator_window_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared state encoding and default sizing for the window controller
package accumulator_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int ACC_WIDTH  = 32;
    localparam int ACC_WINDOW = 10;
    localparam int ACC_DEPTH  = 4;

endpackage

// File: rtl/accumulator_window_ctrl_if.sv
// accumulator_window_ctrl_if: valid/ready result stream leaving the window controller
interface accumulator_window_ctrl_if
    import accumulator_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
);

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sum_fifo.sv
// sum_fifo: synchronous FIFO with wrap-around pointers carrying an extra lap bit for full/empty
module sum_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             wr_en, rd_en;

    assign count = wr_q - rd_q;
    assign empty = wr_q == rd_q;
    assign full  = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign dout  = mem[rd_q[AW-1:0]];
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // a full FIFO still accepts a push when the head leaves on the same edge
    always_comb begin
        wr_d = wr_en ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = rd_en ? rd_q + (AW+1)'(1) : rd_q;
    end

    // pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/accumulator_window_ctrl.sv
// accumulator_window_ctrl: slices the accumulator running total into per-window results
module accumulator_window_ctrl
    import accumulator_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH,
    parameter int WINDOW = ACC_WINDOW,
    parameter int DEPTH  = ACC_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [WIDTH-1:0]            sum,
    output logic                        acc_clr,
    accumulator_window_ctrl_if.master   out_if,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow
);

    localparam int            CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          last, push, pop, empty, full;

    assign last             = state_q == RUN && cnt_q == LAST;
    assign push             = last;
    assign pop              = out_if.out_valid && out_if.out_ready;
    assign acc_clr          = state_q == IDLE || last;
    assign out_if.out_valid = !empty;
    assign overflow         = ovf_q;

    // en alone picks the next state; the window counter restarts on wrap, abort or idle
    always_comb begin
        state_d = en ? RUN : IDLE;
        cnt_d   = (state_q == RUN && en && !last) ? cnt_q + CW'(1) : '0;
        ovf_d   = ovf_q || (push && full && !pop);
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    sum_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (sum),
        .pop  (pop),
        .dout (out_if.out_data),
        .empty(empty),
        .full (full),
        .count(level)
    );

endmodule

// File: tb/tb_accumulator_window_ctrl.sv
// tb_accumulator_window_ctrl: directed checks of windowing, FIFO back-pressure, abort and reset
module tb_accumulator_window_ctrl;
    import accumulator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] acc_sum;
    logic        acc_clr;
    logic [2:0]  level;
    logic        overflow;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          clrs, pops;

    accumulator_window_ctrl_if #(.WIDTH(32)) out_if ();

    accumulator_window_ctrl #(
        .WIDTH (32),
        .WINDOW(10),
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sum     (acc_sum),
        .acc_clr (acc_clr),
        .out_if  (out_if),
        .level   (level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // upstream accumulator, cleared by the controller
    always_ff @(posedge clk) acc_sum <= acc_clr ? 32'd0 : acc_sum + a;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic restart(input logic rdy);
        en = 1'b0;
        a = '0;
        rst = 1'b1;
        out_if.out_ready = rdy;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        out_if.out_ready = 1'b1;
        restart(1'b1);
        check("rst_level", level, 0);
        check("rst_valid", out_if.out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_clr", acc_clr, 1);
        check("rst_idle", dut.state_q == IDLE, 1);

        a = 1; en = 1'b1; step(1);
        check("const_clr_fall", acc_clr, 0);
        step(9);
        check("const_clr_push", acc_clr, 1);
        check("const_valid_pre", out_if.out_valid, 0);
        step(1);
        check("const_valid", out_if.out_valid, 1);
        check("const_data", out_if.out_data, 9);
        check("const_level", level, 1);
        clrs = 0; pops = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            clrs += int'(acc_clr);
            if (out_if.out_valid && out_if.out_ready) begin
                pops++;
                check("const_data_n", out_if.out_data, 9);
            end
        end
        check("const_clr_count", clrs, 2);
        check("const_pop_count", pops, 2);
        check("const_ovf", overflow, 0);

        restart(1'b1);
        a = 3; en = 1'b1; step(10);
        check("chg_valid_pre", out_if.out_valid, 0);
        a = 5; step(1);
        check("chg_valid1", out_if.out_valid, 1);
        check("chg_data1", out_if.out_data, 27);
        step(10);
        check("chg_valid2", out_if.out_valid, 1);
        check("chg_data2", out_if.out_data, 45);

        restart(1'b1);
        a = 32'hFFFF_FFFF; en = 1'b1; step(11);
        check("wrap_valid", out_if.out_valid, 1);
        check("wrap_data", out_if.out_data, 32'hFFFF_FFF7);

        restart(1'b0);
        en = 1'b1; step(1);
        for (int w = 1; w <= 4; w++) begin
            a = w; step(10);
        end
        check("bp_level_full", level, 4);
        check("bp_ovf_pre", overflow, 0);
        for (int w = 5; w <= 6; w++) begin
            a = w; step(10);
        end
        check("bp_level_hold", level, 4);
        check("bp_ovf", overflow, 1);
        en = 1'b0; out_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_valid", out_if.out_valid, 1);
            check("bp_drain_data", out_if.out_data, 9 * (i + 1));
            step(1);
        end
        check("bp_empty", out_if.out_valid, 0);
        check("bp_level_zero", level, 0);
        check("bp_ovf_sticky", overflow, 1);

        restart(1'b0);
        en = 1'b1; step(1);
        for (int w = 1; w <= 4; w++) begin
            a = w; step(10);
        end
        a = 5; step(9);
        check("pp_level_pre", level, 4);
        out_if.out_ready = 1'b1; step(1);
        check("pp_level", level, 4);
        check("pp_ovf", overflow, 0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_valid", out_if.out_valid, 1);
            check("pp_drain_data", out_if.out_data, 9 * (i + 2));
            step(1);
        end
        check("pp_empty", out_if.out_valid, 0);

        restart(1'b1);
        a = 1; en = 1'b1; step(6);
        check("abort_cnt", dut.cnt_q, 5);
        en = 1'b0; step(1);
        check("abort_clr", acc_clr, 1);
        check("abort_idle", dut.state_q == IDLE, 1);
        step(10);
        check("abort_no_push", out_if.out_valid, 0);
        check("abort_level", level, 0);
        en = 1'b1; step(11);
        check("abort_re_valid", out_if.out_valid, 1);
        check("abort_re_data", out_if.out_data, 9);

        restart(1'b1);
        a = 1; en = 1'b1; step(10);
        en = 1'b0; step(1);
        check("droplast_valid", out_if.out_valid, 1);
        check("droplast_data", out_if.out_data, 9);
        check("droplast_idle", dut.state_q == IDLE, 1);
        check("droplast_clr", acc_clr, 1);

        restart(1'b0);
        a = 1; en = 1'b1; step(28);
        check("mid_level", level, 2);
        check("mid_cnt", dut.cnt_q, 7);
        rst = 1'b1; step(1); rst = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", out_if.out_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_clr", acc_clr, 1);
        check("mid_rst_idle", dut.state_q == IDLE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
